// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - data-side bus fabric: RAM, address-mapped I/O slots, timeout and bus error
module mem_bus_fabric #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 8,
    parameter int                 RAM_DEPTH   = 192,
    parameter logic [ADDR_W-1:0]  IO_BASE     = 'hF0,
    parameter int                 NUM_IO      = 4,
    parameter int                 IO_REG_BITS = 2,
    parameter int                 TIMEOUT     = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       writeEnable,
    input  logic [ADDR_W-1:0]          Address,
    input  logic [DATA_W-1:0]          WriteData,
    output logic [DATA_W-1:0]          Data,
    output logic                       ready,
    output logic                       busError,
    output logic [NUM_IO-1:0]          ioSel,
    output logic                       ioRead,
    output logic                       ioWrite,
    output logic [IO_REG_BITS-1:0]     ioRegSelect,
    output logic [DATA_W-1:0]          ioWriteData,
    input  logic [NUM_IO*DATA_W-1:0]   ioReadData,
    input  logic [NUM_IO-1:0]          ioReady
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IO_REQ  = 2'd1;
    localparam logic [1:0] IO_WAIT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int                RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int                CW      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   RAM_LIM = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] NUM_IO_A = ADDR_W'(NUM_IO);
    localparam logic [CW-1:0]     TO_V    = CW'(TIMEOUT);

    logic [1:0]         state;
    logic               we_q;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;

    logic [DATA_W-1:0]  ram [RAM_DEPTH];
    logic [DATA_W-1:0]  ram_rd;

    logic               is_ram;
    logic               is_io;
    logic [ADDR_W-1:0]  io_off;
    logic [ADDR_W-1:0]  io_slot;
    logic [NUM_IO-1:0]  sel_dec;
    logic [DATA_W-1:0]  rd_sel;
    logic               slot_rdy;

    // Address decode of the request presented in IDLE; results are latched at accept
    always_comb begin
        is_ram  = ({1'b0, Address} < RAM_LIM);
        io_off  = Address - IO_BASE;
        io_slot = io_off >> IO_REG_BITS;
        is_io   = !is_ram && (Address >= IO_BASE) && (io_slot < NUM_IO_A);
        sel_dec = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            sel_dec[k] = (io_slot == ADDR_W'(k));
        end
    end

    assign ram_rd  = ram[Address[RAM_AW-1:0]];
    assign cnt_nxt = cnt + CW'(1);

    // Only the selected slot's ready and read data are looked at
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (ioSel[k]) begin
                rd_sel = rd_sel | ioReadData[k*DATA_W +: DATA_W];
            end
        end
    end

    assign slot_rdy = |(ioReady & ioSel);

    always_ff @(posedge clk) begin
        if (reset && state == IDLE && req && writeEnable && is_ram) begin
            ram[Address[RAM_AW-1:0]] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            cnt         <= '0;
            Data        <= '0;
            ready       <= 1'b0;
            busError    <= 1'b0;
            ioSel       <= '0;
            ioRead      <= 1'b0;
            ioWrite     <= 1'b0;
            ioRegSelect <= '0;
            ioWriteData <= '0;
        end else begin
            ready    <= 1'b0;
            busError <= 1'b0;
            ioRead   <= 1'b0;
            ioWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q <= writeEnable;
                        if (is_ram) begin
                            if (!writeEnable) begin
                                Data <= ram_rd;
                            end
                            ready <= 1'b1;
                            state <= DONE;
                        end else if (is_io) begin
                            ioSel       <= sel_dec;
                            ioRegSelect <= Address[IO_REG_BITS-1:0];
                            ioRead      <= !writeEnable;
                            ioWrite     <= writeEnable;
                            if (writeEnable) begin
                                ioWriteData <= WriteData;
                            end
                            cnt   <= '0;
                            state <= IO_REQ;
                        end else begin
                            Data     <= '0;
                            busError <= 1'b1;
                            ready    <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                IO_REQ, IO_WAIT: begin
                    // A ready in the cycle the counter would expire still wins
                    if (slot_rdy) begin
                        if (!we_q) begin
                            Data <= rd_sel;
                        end
                        ready <= 1'b1;
                        ioSel <= '0;
                        state <= DONE;
                    end else if (cnt_nxt == TO_V) begin
                        Data     <= '0;
                        busError <= 1'b1;
                        ready    <= 1'b1;
                        ioSel    <= '0;
                        state    <= DONE;
                    end else begin
                        cnt   <= cnt_nxt;
                        state <= IO_WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// tb/tb_mem_bus_fabric.sv - scoreboard bench for mem_bus_fabric with three I/O slots
module tb_mem_bus_fabric;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        writeEnable = 1'b0;
    logic [7:0]  Address = 8'h00;
    logic [7:0]  WriteData = 8'h00;
    logic [7:0]  Data;
    logic        ready;
    logic        busError;
    logic [2:0]  ioSel;
    logic        ioRead;
    logic        ioWrite;
    logic [1:0]  ioRegSelect;
    logic [7:0]  ioWriteData;
    logic [23:0] ioReadData = 24'h0;
    logic [2:0]  ioReady = 3'b000;

    mem_bus_fabric #(
        .ADDR_W(8), .DATA_W(8), .RAM_DEPTH(192), .IO_BASE(8'hF0),
        .NUM_IO(3), .IO_REG_BITS(2), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .writeEnable(writeEnable),
        .Address(Address), .WriteData(WriteData), .Data(Data), .ready(ready),
        .busError(busError), .ioSel(ioSel), .ioRead(ioRead), .ioWrite(ioWrite),
        .ioRegSelect(ioRegSelect), .ioWriteData(ioWriteData),
        .ioReadData(ioReadData), .ioReady(ioReady)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ioRead) rd_cnt++;
        if (ioWrite) wr_cnt++;
        if (reset && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data", {24'h0, Data}, {24'h0, mon_e.d});
                chk("buserror", {31'h0, busError}, {31'h0, mon_e.e});
                chk("ready_cycle", cyc, mon_e.c);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("pending_responses", sb.size(), 0);
        sb.delete();
    endtask

    // Issue one access from a falling edge; lat = cycles from accept edge to ready
    task automatic access(input logic [7:0] a, input logic we, input logic [7:0] wd,
                          input logic [7:0] ed, input logic ee, input int lat);
        req = 1'b1;
        Address = a;
        writeEnable = we;
        WriteData = wd;
        @(posedge clk);
        #1;
        sb.push_back('{ed, ee, cyc + lat - 1});
        req = 1'b0;
        Address = 8'($urandom);
        WriteData = 8'($urandom);
        drain();
    endtask

    // Slot model: wait for the strobe, hold off dly cycles, then pulse ioReady (dly<0: never)
    task automatic respond(input int slot, input logic [1:0] rs, input logic [7:0] wd,
                           input int dly, input logic [7:0] d);
        logic [2:0] one;
        bit seen;
        one = 3'b001 << slot;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ioRead || ioWrite) begin
                seen = 1'b1;
                break;
            end
        end
        chk("strobe_seen", {31'h0, seen}, 32'd1);
        chk("ioregselect", {30'h0, ioRegSelect}, {30'h0, rs});
        if (ioWrite) chk("iowritedata", {24'h0, ioWriteData}, {24'h0, wd});
        if (dly >= 0) begin
            for (int i = 0; i < dly; i++) begin
                chk("iosel_held", {29'h0, ioSel}, {29'h0, one});
                @(negedge clk);
                if (ioRead || ioWrite) chk("extra_strobe", 32'd1, 32'd0);
            end
            chk("iosel_held", {29'h0, ioSel}, {29'h0, one});
            ioReady[slot] = 1'b1;
            ioReadData[slot*8 +: 8] = d;
            @(negedge clk);
            ioReady[slot] = 1'b0;
        end
    endtask

    int r0;
    int w0;
    int a0;

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {7'h0, Data, ready, busError, ioSel, ioRead, ioWrite, ioRegSelect, ioWriteData}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        access(8'h10, 1'b1, 8'hA5, 8'h00, 1'b0, 1);
        access(8'h20, 1'b1, 8'h3B, 8'h00, 1'b0, 1);
        access(8'h10, 1'b0, 8'h00, 8'hA5, 1'b0, 1);

        r0 = rd_cnt; w0 = wr_cnt;
        access(8'hC8, 1'b0, 8'h00, 8'h00, 1'b1, 1);
        access(8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1);
        access(8'hC8, 1'b1, 8'h77, 8'h00, 1'b1, 1);
        chk("unmapped_strobes", rd_cnt - r0 + wr_cnt - w0, 0);
        access(8'h10, 1'b0, 8'h00, 8'hA5, 1'b0, 1);

        r0 = rd_cnt; w0 = wr_cnt;
        fork
            access(8'hF6, 1'b0, 8'h00, 8'h3C, 1'b0, 5);
            respond(1, 2'd2, 8'h00, 3, 8'h3C);
        join
        chk("io_read_pulses", rd_cnt - r0, 1);
        chk("io_read_wpulses", wr_cnt - w0, 0);

        ioReadData[7:0] = 8'h11;
        ioReady[0] = 1'b1;
        fork
            access(8'hF8, 1'b0, 8'h00, 8'h77, 1'b0, 4);
            respond(2, 2'd0, 8'h00, 2, 8'h77);
        join
        ioReady[0] = 1'b0;

        r0 = rd_cnt; w0 = wr_cnt;
        fork
            access(8'hF0, 1'b1, 8'h5E, 8'h00, 1'b1, 16);
            respond(0, 2'd0, 8'h5E, -1, 8'h00);
        join
        chk("timeout_wpulses", wr_cnt - w0, 1);
        chk("timeout_rpulses", rd_cnt - r0, 0);

        fork
            access(8'hF5, 1'b0, 8'h00, 8'h5A, 1'b0, 16);
            respond(1, 2'd1, 8'h00, 14, 8'h5A);
        join

        req = 1'b1; Address = 8'hF4; writeEnable = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_mid_access", {7'h0, Data, ready, busError, ioSel, ioRead, ioWrite, ioRegSelect, ioWriteData}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access(8'h10, 1'b0, 8'h00, 8'hA5, 1'b0, 1);

        req = 1'b1; writeEnable = 1'b0; Address = 8'h10;
        @(posedge clk);
        #1 a0 = cyc;
        sb.push_back('{8'hA5, 1'b0, a0});
        Address = 8'h20;
        @(posedge clk);
        @(posedge clk);
        #1 sb.push_back('{8'h3B, 1'b0, a0 + 2});
        Address = 8'hC8;
        @(posedge clk);
        @(posedge clk);
        #1 sb.push_back('{8'h00, 1'b1, a0 + 4});
        req = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised memory-mapped bus fabric between the CPU load/store port and the data RAM plus up to NUM_IO peripheral slots. It generalises fixed RAM/UART decode to a configurable address map, adds a request/ready handshake with variable-latency peripherals, a per-access timeout, and bus-error reporting for unmapped addresses. It sits between the CPU datapath and all data-side memory and I/O.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- RAM_DEPTH, 192, RAM words, mapped at 0..RAM_DEPTH-1; must be ≤ IO_BASE
- IO_BASE, 8'hF0, first I/O address
- NUM_IO, 4, peripheral slots, 1..8
- IO_REG_BITS, 2, register-select bits per slot
- TIMEOUT, 15, maximum I/O wait cycles, ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- req  in  1  access request
- writeEnable  in  1  1 = write, 0 = read
- Address  in  ADDR_W  byte address
- WriteData  in  DATA_W  write data
- Data  out  DATA_W  read data, registered
- ready  out  1  one-cycle completion pulse
- busError  out  1  qualifies ready: access failed
- ioSel  out  NUM_IO  one-hot slot select, held for the entire I/O access
- ioRead, ioWrite  out  1  one-cycle strobes
- ioRegSelect  out  IO_REG_BITS  register within slot
- ioWriteData  out  DATA_W  latched write data
- ioReadData  in  NUM_IO*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W]
- ioReady  in  NUM_IO  per-slot completion

## Operation
- Decode of the latched address:
  - RAM when Address < RAM_DEPTH.
  - I/O when Address ≥ IO_BASE:
    - slot = (Address - IO_BASE) >> IO_REG_BITS
    - reg = low IO_REG_BITS bits of Address
    - slot ≥ NUM_IO is unmapped.
  - Every other address is unmapped.
- FSM states: IDLE, IO_REQ, IO_WAIT, DONE.
- IDLE: when req=1, latch Address, WriteData and writeEnable, then take exactly one branch:
  - RAM write: write the RAM word; go to DONE; Data unchanged.
  - RAM read: Data ← RAM[Address]; go to DONE.
  - Unmapped: set error flag; Data ← 0; go to DONE; RAM unchanged.
  - I/O: go to IO_REQ; clear the timeout counter.
- IO_REQ (exactly one cycle):
  - Drive ioSel[slot] and ioRegSelect.
  - Assert ioRead or ioWrite for this cycle only.
- IO_WAIT: hold ioSel, ioRegSelect and ioWriteData; strobes are low.
- ioReady[slot] is sampled in both IO_REQ and IO_WAIT:
  - When high: on a read, Data ← ioReadData slice of that slot; go to DONE.
  - When low: the counter increments. If the counter would reach TIMEOUT, set error, Data ← 0, go to DONE.
- ioReady bits of unselected slots are ignored.
- DONE: ready=1; busError = error flag; always returns to IDLE. req is ignored in DONE.
- Data holds its value from the last completed read (or 0 after an error) until the next read or error completes.
- RAM contents are not cleared by reset.

## Timing
- Reset (async assert) forces state IDLE and clears:
  - Data, ready, busError, ioSel, ioRead, ioWrite, ioRegSelect, ioWriteData
  - counter and error flag
- A reset that arrives mid-access aborts it: no ready is produced, and a RAM write is lost unless its accept edge has already occurred.
- RAM or unmapped access: req accepted at edge N; ready high during cycle N+1. Throughput is one access per 2 cycles.
- I/O access with ioReady already high in IO_REQ: ready is high 2 cycles after accept.
- Each IO_WAIT cycle adds 1 cycle of latency.
- Timeout: after TIMEOUT cycles without ioReady across IO_REQ+IO_WAIT, DONE follows with busError=1.
- ioReady arriving in the same cycle the counter expires counts as success; no error.
- A req still held high in DONE starts a new access in the following IDLE cycle. The requester drops req during the ready cycle to avoid this.
- Inputs may change freely after the accept edge.

## Test plan
- RAM write 8'h10 ← 8'hA5, then read 8'h10 → ready one cycle after each accept, Data=8'hA5, busError=0.
- Read 8'hC8 (between RAM_DEPTH and IO_BASE) and 8'hFF with NUM_IO=3 → ready with busError=1, Data=0, no io strobe; RAM unchanged.
- I/O read at 8'hF6 (slot 1, reg 2), ioReady[1] asserted 3 cycles after the strobe, slice = 8'h3C → one ioRead pulse, ioSel=4'b0010 held throughout, Data=8'h3C, ready 5 cycles after accept.
- I/O write at 8'hF0 with ioReady never asserted, TIMEOUT=15 → one ioWrite pulse, ready with busError=1 exactly 16 cycles after accept, then return to IDLE.
- ioReady[0] high while slot 2 is selected → ignored; the access waits for ioReady[2].
- Reset asserted during IO_WAIT → all outputs 0 immediately, no ready; a new RAM read after release completes normally. req held high across DONE → back-to-back accesses every 2 cycles.
